// File: rtl/instr_trace.sv
// Instruction-trace recorder: circular capture of {pc, opcode, operand} around an opcode trigger.
// Optional TRACE_NOP_FILTER_EN: opcode 0 fetches are neither recorded nor counted.
module instr_trace #(
   parameter int OP_W      = 4,
   parameter int ARG_W     = 8,
   parameter int PC_W      = 8,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           fetch_valid,
   input  logic [PC_W-1:0]                pc,
   input  logic [OP_W-1:0]                opcode,
   input  logic [ARG_W-1:0]               operand,
   input  logic                           arm,
   input  logic                           abort,
   input  logic [OP_W-1:0]                trig_op,
   output logic                           rd_valid,
   input  logic                           rd_ready,
   output logic [PC_W+OP_W+ARG_W-1:0]     rd_data,
   output logic [1:0]                     state,
   output logic [$clog2(DEPTH):0]         level,
   output logic                           wrapped
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = PC_W + OP_W + ARG_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          st;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   post_cnt;
   logic [EW-1:0]   mem [DEPTH];
   logic            pass;
   logic            rec;
   logic            full;
   logic            pop;

`ifdef TRACE_NOP_FILTER_EN
   assign pass = (opcode != '0);
`else
   assign pass = 1'b1;
`endif

   assign rec      = fetch_valid && pass && ((st == ARMED) || (st == POST));
   assign full     = (level == LW'(DEPTH));
   assign rd_valid = (st == DONE) && (level != '0);
   assign pop      = rd_valid && rd_ready;
   // Oldest entry sits level slots behind the write pointer; popping just shrinks level.
   assign rd_ptr   = wr_ptr - level[AW-1:0];
   assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
   assign state    = st;

   always_ff @(posedge clk) begin
      if (rec) begin
         mem[wr_ptr] <= {pc, opcode, operand};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st       <= IDLE;
         wr_ptr   <= '0;
         level    <= '0;
         wrapped  <= 1'b0;
         post_cnt <= '0;
      end else if (abort) begin
         st       <= IDLE;
         wr_ptr   <= '0;
         level    <= '0;
         wrapped  <= 1'b0;
         post_cnt <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (arm) begin
                  st       <= ARMED;
                  wr_ptr   <= '0;
                  level    <= '0;
                  wrapped  <= 1'b0;
                  post_cnt <= '0;
               end
            end
            ARMED, POST: begin
               if (rec) begin
                  wr_ptr <= wr_ptr + AW'(1);
                  if (full) begin
                     wrapped <= 1'b1;
                  end else begin
                     level <= level + LW'(1);
                  end
                  if (st == ARMED) begin
                     if (opcode == trig_op) begin
                        post_cnt <= AW'(POST_TRIG);
                        st       <= (POST_TRIG == 0) ? DONE : POST;
                     end
                  end else begin
                     post_cnt <= post_cnt - AW'(1);
                     if (post_cnt == AW'(1)) begin
                        st <= DONE;
                     end
                  end
               end
            end
            DONE: begin
               if (pop) begin
                  level <= level - LW'(1);
                  if (level == LW'(1)) begin
                     st <= IDLE;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_trace.sv
// Bench for instr_trace: vector table for the basic capture, scoreboard queue for drained entries.
module tb_instr_trace;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [7:0]  pc;
   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic        arm;
   logic        abort;
   logic [3:0]  trig_op;
   logic        rd_ready;
   logic        rd_valid,  z_rd_valid;
   logic [19:0] rd_data,   z_rd_data;
   logic [1:0]  state,     z_state;
   logic [4:0]  level,     z_level;
   logic        wrapped,   z_wrapped;

   int tests = 0;
   int fails = 0;

   logic [19:0] sb[$];
   int          m_state = 0;
   int          m_cnt = 0;

   typedef struct {
      logic [7:0] pc;
      logic [3:0] op;
      int         exp_state;
      int         exp_level;
   } vec_t;
   vec_t basic[8];

   always #5 clk = ~clk;

   instr_trace #(.OP_W(4), .ARG_W(8), .PC_W(8), .DEPTH(16), .POST_TRIG(4)) dut (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .pc(pc), .opcode(opcode),
      .operand(operand), .arm(arm), .abort(abort), .trig_op(trig_op),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .state(state), .level(level), .wrapped(wrapped));

   instr_trace #(.OP_W(4), .ARG_W(8), .PC_W(8), .DEPTH(16), .POST_TRIG(0)) dut_z (
      .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .pc(pc), .opcode(opcode),
      .operand(operand), .arm(arm), .abort(abort), .trig_op(trig_op),
      .rd_valid(z_rd_valid), .rd_ready(rd_ready), .rd_data(z_rd_data),
      .state(z_state), .level(z_level), .wrapped(z_wrapped));

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [7:0] p, input logic [3:0] op);
      bit          pass;
      logic [19:0] tmp;
      pass = 1'b1;
`ifdef TRACE_NOP_FILTER_EN
      pass = (op != 4'd0);
`endif
      if ((m_state == 1 || m_state == 2) && pass) begin
         sb.push_back({p, op, p ^ 8'h5A});
         if (sb.size() > 16) tmp = sb.pop_front();
         if (m_state == 1 && op == trig_op) begin
            m_state = 2;
            m_cnt   = 4;
         end else if (m_state == 2) begin
            m_cnt--;
            if (m_cnt == 0) m_state = 3;
         end
      end
      fetch_valid = 1'b1;
      pc          = p;
      opcode      = op;
      operand     = p ^ 8'h5A;
      cyc();
      fetch_valid = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      cyc();
      arm = 1'b0;
      m_state = 1;
      sb.delete();
   endtask

   task automatic drain(input string name, output logic [19:0] last);
      logic [19:0] e;
      last = '0;
      rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (!rd_valid) break;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s extra: got %0d expected no entry", name, rd_data);
            break;
         end
         e = sb.pop_front();
         check(name, rd_data, e);
         last = rd_data;
         cyc();
      end
      rd_ready = 1'b0;
      check("drain scoreboard empty", sb.size(), 0);
      check("drain state idle", state, 0);
      check("drain rd_valid low", rd_valid, 0);
      m_state = 0;
   endtask

   initial begin
      logic [19:0] last;
      logic [19:0] tmp;
      logic [3:0]  fops [12];

      basic[0] = '{8'd0, 4'd4,  1, 1};
      basic[1] = '{8'd1, 4'd6,  1, 2};
      basic[2] = '{8'd2, 4'd12, 1, 3};
      basic[3] = '{8'd3, 4'd13, 2, 4};
      basic[4] = '{8'd4, 4'd1,  2, 5};
      basic[5] = '{8'd5, 4'd13, 2, 6};
      basic[6] = '{8'd6, 4'd2,  2, 7};
      basic[7] = '{8'd7, 4'd3,  3, 8};
      fops = '{4'd0, 4'd4, 4'd0, 4'd13, 4'd0, 4'd5, 4'd0, 4'd6, 4'd0, 4'd7, 4'd0, 4'd8};

      reset = 1'b1; fetch_valid = 1'b0; pc = '0; opcode = '0; operand = '0;
      arm = 1'b0; abort = 1'b0; trig_op = 4'd13; rd_ready = 1'b0;
      cyc(); cyc();
      check("reset state", state, 0);
      check("reset level", level, 0);
      check("reset wrapped", wrapped, 0);
      check("reset rd_valid", rd_valid, 0);
      check("reset rd_data", rd_data, 0);
      reset = 1'b0;
      cyc();

      // fetch and trigger while idle are ignored
      do_fetch(8'd9, 4'd13);
      check("idle fetch level", level, 0);
      check("idle fetch state", state, 0);

      // basic capture from the vector table
      do_arm();
      check("armed state", state, 1);
      check("armed level", level, 0);
      for (int i = 0; i < 8; i++) begin
         do_fetch(basic[i].pc, basic[i].op);
         check($sformatf("basic state %0d", i), state, basic[i].exp_state);
         check($sformatf("basic level %0d", i), level, basic[i].exp_level);
      end
      check("basic rd_valid", rd_valid, 1);
      check("basic wrapped", wrapped, 0);

      // arm in DONE is ignored
      arm = 1'b1; cyc(); arm = 1'b0;
      check("arm in done state", state, 3);
      check("arm in done level", level, 8);

      // backpressure then a single-cycle pop
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp rd_data held", rd_data, sb[0]);
         check("bp level held", level, 8);
      end
      rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
      tmp = sb.pop_front();
      check("pulse pop level", level, 7);
      check("pulse pop next data", rd_data, sb[0]);
      cyc();
      check("pulse single pop", level, 7);
      drain("basic drain", last);
      check("basic last pc", last[19:12], 7);

      // wrap: 25 entries into 16 slots
      do_arm();
      for (int i = 0; i < 20; i++) do_fetch(8'(i), 4'd1);
      do_fetch(8'd20, 4'd13);
      for (int i = 21; i < 25; i++) do_fetch(8'(i), 4'd2);
      check("wrap state", state, 3);
      check("wrap level", level, 16);
      check("wrap wrapped", wrapped, 1);
      check("wrap first pc", rd_data[19:12], 9);
      drain("wrap drain", last);
      check("wrap last pc", last[19:12], 24);

      // asynchronous reset mid-POST
      do_arm();
      for (int i = 0; i < 5; i++) do_fetch(8'(i), (i == 3) ? 4'd13 : 4'd4);
      check("pre-reset state", state, 2);
      check("pre-reset level", level, 5);
      #2 reset = 1'b1;
      #1;
      check("async reset state", state, 0);
      check("async reset level", level, 0);
      check("async reset wrapped", wrapped, 0);
      check("async reset rd_valid", rd_valid, 0);
      cyc();
      reset = 1'b0;
      m_state = 0;
      sb.delete();
      cyc();

      // POST_TRIG=0 on the second instance, then abort+arm together
      do_arm();
      for (int i = 0; i < 4; i++) do_fetch(8'(i), (i == 3) ? 4'd13 : 4'd4);
      check("pt0 state", z_state, 3);
      check("pt0 level", z_level, 4);
      check("pt0 rd_valid", z_rd_valid, 1);
      check("pt0 first pc", z_rd_data[19:12], 0);
      check("pt4 state", state, 2);
      check("pt4 level", level, 4);
      abort = 1'b1; arm = 1'b1; cyc(); abort = 1'b0; arm = 1'b0;
      m_state = 0;
      sb.delete();
      check("abort+arm state", state, 0);
      check("abort+arm level", level, 0);
      check("abort+arm z state", z_state, 0);
      check("abort+arm z level", z_level, 0);

      // NOP filter stream
      do_arm();
      for (int i = 0; i < 12; i++) do_fetch(8'(i), fops[i]);
      check("filter state", state, 3);
`ifdef TRACE_NOP_FILTER_EN
      check("filter level", level, 6);
`else
      check("filter level", level, 8);
`endif
      drain("filter drain", last);
`ifdef TRACE_NOP_FILTER_EN
      check("filter last op", last[11:8], 8);
`else
      check("filter last op", last[11:8], 6);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
